ms_tmr32_arb: RTL and testbench
===============================

// Module: ms_tmr32_arb
// PURPOSE
//  Shares one ms_tmr32 instance between NREQ requesters that each need a one-shot delay.
//  Round-robin arbiter plus sequencer: picks a requester, loads its period and clock source,
//  runs the timer in down-counting one-shot mode, signals completion and releases the timer.
//  Sits between software-visible delay channels and the ms_tmr32 configuration inputs.
// PARAMETERS
//  NREQ  4  number of requesters (2..8)
// PORTS
//  clk          in   1        system clock
//  rst_n        in   1        asynchronous active-low reset
//  req          in   NREQ     level request per requester; held high until done or withdrawn
//  req_period   in   32*NREQ  delay in timer ticks, requester i at [32*i+31:32*i]
//  req_clk_src  in   4*NREQ   ms_tmr32 clk_src code, requester i at [4*i+3:4*i]
//  gnt          out  NREQ     one-hot grant; high while requester owns the timer
//  done         out  NREQ     one-hot, one-cycle pulse: granted delay expired
//  busy         out  1        timer owned (state LOAD or RUN)
//  tmr_en       out  1        to ms_tmr32.tmr_en
//  tmr_period   out  32       to ms_tmr32.period (latched copy)
//  tmr_clk_src  out  4        to ms_tmr32.clk_src (latched copy)
//  tmr_up       out  1        constant 0 (down count)
//  tmr_one_shot out  1        constant 1
//  to_flag      in   1        from ms_tmr32.to_flag
// BEHAVIOUR
//  Reset: state IDLE, gnt=0, done=0, busy=0, tmr_en=0, tmr_period=0, tmr_clk_src=0, rr ptr=0.
//  All outputs registered except constants. States IDLE, LOAD, RUN.
//  IDLE: eligible = req & ~done. If none -> stay. Else pick first eligible at/after ptr
//   (wrapping). At the edge: gnt<=onehot(k), latch period/clk_src of k, ptr<=(k+1)%NREQ.
//   If latched period!=0 -> LOAD. If period==0 -> stay IDLE, gnt<=0, and done[k]<=1 on the
//   same edge (zero-delay bypass, timer untouched, tmr_en stays 0, gnt never pulses).
//  LOAD (1 cycle): tmr_en=0 so ms_tmr32 loads tmr<=tmr_period; -> RUN with tmr_en<=1.
//  RUN: tmr_en=1. On to_flag: done<=gnt, gnt<=0, tmr_en<=0, -> IDLE.
//  Latency: req rise in IDLE -> gnt next cycle -> tmr_en 2 cycles after req. Expiry is P timer
//   ticks after tmr_en rises; done 1 cycle after to_flag.
//  Withdraw: req[k] low in LOAD or RUN -> IDLE next edge, gnt<=0, tmr_en<=0, no done pulse.
//  Simultaneous to_flag and withdraw in RUN: to_flag wins, done pulses.
//  to_flag in LOAD or IDLE ignored (timer reload value may read 0 before load).
//  req_period/req_clk_src changes while granted are ignored; latched copy used.
//  done pulse masks the same requester for that IDLE cycle so a late-dropping req is not
//   re-granted; a requester that keeps req high is re-granted after done when next in RR order.
//  Fairness: max wait for a requester = (NREQ-1) complete services.
//  Reset mid-operation: immediate return to reset values; tmr_en drops asynchronously.
// STRUCTURE
//  Package ms_tmr32_pkg: state enum (IDLE/LOAD/RUN), TMR_W=32, CLKSRC_W=4, CLK_SRC_CTR=4'd9.
//  Sub-module ms_rr_pick: combinational round-robin picker (eligible, ptr -> onehot, idx, any).
//  Top holds FSM, latches, ptr, outputs.
// TESTING
//  Single req[0], period=5, clk_src=8 -> gnt[0] cycle 1, tmr_en cycle 2, done[0] 1 cycle after to_flag (~cycle 8).
//  req=4'b1111 all period=3 -> grants in order 0,1,2,3 then 0; each done exactly once per service.
//  req[2] period=0 -> done[2] pulse 1 cycle after req, gnt[2] and tmr_en never assert.
//  req[1] period=100, drop req[1] in RUN at cycle 20 -> gnt=0, tmr_en=0 next cycle, no done.
//  rst_n low during RUN -> all outputs 0 at once; after release req still high -> regranted from ptr 0.
//  req[3] held high after done with req[0] pending -> req[0] served before req[3] again.

Source files
------------

// File: rtl/ms_tmr32_pkg.sv
// Shared definitions for the ms_tmr32 requester arbiter: FSM encodings,
// timer field widths and the counter clock-source code.
package ms_tmr32_pkg;

  localparam int TMR_W    = 32;
  localparam int CLKSRC_W = 4;

  localparam logic [CLKSRC_W-1:0] CLK_SRC_CTR = 4'd9;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_LOAD = 2'd1;
  localparam state_t ST_RUN  = 2'd2;

endpackage

// File: rtl/ms_rr_pick.sv
// Combinational round-robin picker: first eligible requester at or after ptr,
// wrapping, returned as one-hot, index and an any-eligible flag.
module ms_rr_pick
  import ms_tmr32_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int PTR_W = 2
) (
  input  logic [NREQ-1:0]  eligible,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  onehot,
  output logic [PTR_W-1:0] idx,
  output logic             any
);

  int cand;

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    cand   = 0;
    for (int i = 0; i < NREQ; i++) begin
      cand = (int'(ptr) + i) % NREQ;
      if (!any && eligible[cand]) begin
        onehot[cand] = 1'b1;
        idx          = PTR_W'(cand);
        any          = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ms_tmr32_arb.sv
// Round-robin sharing of one ms_tmr32 among NREQ one-shot delay requesters:
// picks a requester, loads the timer, runs it down and reports completion.
module ms_tmr32_arb
  import ms_tmr32_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req,
  input  logic [TMR_W*NREQ-1:0]    req_period,
  input  logic [CLKSRC_W*NREQ-1:0] req_clk_src,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          done,
  output logic                     busy,
  output logic                     tmr_en,
  output logic [TMR_W-1:0]         tmr_period,
  output logic [CLKSRC_W-1:0]      tmr_clk_src,
  output logic                     tmr_up,
  output logic                     tmr_one_shot,
  input  logic                     to_flag
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t              state_q, state_d;
  logic [NREQ-1:0]     gnt_q, gnt_d;
  logic [NREQ-1:0]     done_q, done_d;
  logic                busy_q, busy_d;
  logic                tmr_en_q, tmr_en_d;
  logic [TMR_W-1:0]    period_q, period_d;
  logic [CLKSRC_W-1:0] clk_src_q, clk_src_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;

  logic [NREQ-1:0]     eligible;
  logic [NREQ-1:0]     pick_onehot;
  logic [PTR_W-1:0]    pick_idx;
  logic                pick_any;
  logic [TMR_W-1:0]    pick_period;
  logic [CLKSRC_W-1:0] pick_clk_src;

  // A requester that just got its done pulse sits out one arbitration round
  assign eligible = req & ~done_q;

  ms_rr_pick #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .eligible (eligible),
    .ptr      (ptr_q),
    .onehot   (pick_onehot),
    .idx      (pick_idx),
    .any      (pick_any)
  );

  always_comb begin
    pick_period  = req_period[int'(pick_idx)*TMR_W +: TMR_W];
    pick_clk_src = req_clk_src[int'(pick_idx)*CLKSRC_W +: CLKSRC_W];
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    done_d    = '0;
    tmr_en_d  = tmr_en_q;
    period_d  = period_q;
    clk_src_d = clk_src_q;
    ptr_d     = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          period_d  = pick_period;
          clk_src_d = pick_clk_src;
          ptr_d     = (int'(pick_idx) == NREQ-1) ? '0 : pick_idx + 1'b1;
          // Zero delay completes immediately without touching the timer
          if (pick_period != '0) begin
            gnt_d   = pick_onehot;
            state_d = ST_LOAD;
          end else begin
            gnt_d  = '0;
            done_d = pick_onehot;
          end
        end
      end
      ST_LOAD: begin
        if ((gnt_q & req) == '0) begin
          gnt_d    = '0;
          tmr_en_d = 1'b0;
          state_d  = ST_IDLE;
        end else begin
          tmr_en_d = 1'b1;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        if (to_flag) begin
          done_d   = gnt_q;
          gnt_d    = '0;
          tmr_en_d = 1'b0;
          state_d  = ST_IDLE;
        end else if ((gnt_q & req) == '0) begin
          gnt_d    = '0;
          tmr_en_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        gnt_d    = '0;
        tmr_en_d = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
    busy_d = (state_d == ST_LOAD) || (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      done_q    <= '0;
      busy_q    <= 1'b0;
      tmr_en_q  <= 1'b0;
      period_q  <= '0;
      clk_src_q <= '0;
      ptr_q     <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      tmr_en_q  <= tmr_en_d;
      period_q  <= period_d;
      clk_src_q <= clk_src_d;
      ptr_q     <= ptr_d;
    end
  end

  assign gnt          = gnt_q;
  assign done         = done_q;
  assign busy         = busy_q;
  assign tmr_en       = tmr_en_q;
  assign tmr_period   = period_q;
  assign tmr_clk_src  = clk_src_q;
  assign tmr_up       = 1'b0;
  assign tmr_one_shot = 1'b1;

endmodule

// File: tb/tb_ms_tmr32_arb.sv
// Scoreboard bench for ms_tmr32_arb: a behavioural one-shot timer drives to_flag,
// expected grant and done events are queued by the stimulus and popped by a monitor.
module tb_ms_tmr32_arb;

  logic         clk;
  logic         rst_n;
  logic [3:0]   req;
  logic [127:0] req_period;
  logic [15:0]  req_clk_src;
  logic [3:0]   gnt;
  logic [3:0]   done;
  logic         busy;
  logic         tmr_en;
  logic [31:0]  tmr_period;
  logic [3:0]   tmr_clk_src;
  logic         tmr_up;
  logic         tmr_one_shot;
  logic         to_flag;

  logic [31:0]  model_cnt;
  logic         model_flag;
  logic         force_flag;
  logic [3:0]   prev_gnt;

  logic [3:0]   exp_gnt_q[$];
  logic [3:0]   exp_done_q[$];

  int checks;
  int fails;
  int cyc;

  ms_tmr32_arb #(.NREQ(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .req_period   (req_period),
    .req_clk_src  (req_clk_src),
    .gnt          (gnt),
    .done         (done),
    .busy         (busy),
    .tmr_en       (tmr_en),
    .tmr_period   (tmr_period),
    .tmr_clk_src  (tmr_clk_src),
    .tmr_up       (tmr_up),
    .tmr_one_shot (tmr_one_shot),
    .to_flag      (to_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural one-shot down counter ticking every clock: reloads while
  // disabled, raises its flag for one cycle when the count reaches zero.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_cnt  <= '0;
      model_flag <= 1'b0;
    end else if (!tmr_en) begin
      model_cnt  <= tmr_period;
      model_flag <= 1'b0;
    end else if (model_cnt != 0) begin
      model_cnt  <= model_cnt - 1;
      model_flag <= (model_cnt == 1);
    end else begin
      model_flag <= 1'b0;
    end
  end

  assign to_flag = model_flag | force_flag;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input int k, input logic r, input logic [31:0] p, input logic [3:0] src);
    req[k]                = r;
    req_period[k*32 +: 32] = p;
    req_clk_src[k*4 +: 4]  = src;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    req   = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Waits for a done bit in mask; an expired budget counts as a failed comparison
  task automatic waitDone(input logic [3:0] mask, input int budget, output int cycles);
    cycles = 0;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if ((done & mask) != 0) begin
        cycles = i;
        return;
      end
    end
    checks++;
    fails++;
    $display("[TB] FAIL wait_done mask=%b: no done within %0d cycles", mask, budget);
  endtask

  // Monitor: every new grant and every done pulse is matched against the scoreboard
  always @(negedge clk) begin
    if (gnt != 0 && gnt != prev_gnt) begin
      if (exp_gnt_q.size() == 0) begin
        checks++;
        fails++;
        $display("[TB] FAIL unexpected_grant: got %b, expected none", gnt);
      end else begin
        checkOutput("grant_order", 64'(gnt), 64'(exp_gnt_q.pop_front()));
      end
    end
    prev_gnt = gnt;
    if (done != 0) begin
      if (exp_done_q.size() == 0) begin
        checks++;
        fails++;
        $display("[TB] FAIL unexpected_done: got %b, expected none", done);
      end else begin
        checkOutput("done_order", 64'(done), 64'(exp_done_q.pop_front()));
      end
    end
  end

  initial begin
    logic [3:0] order [5];
    checks      = 0;
    fails       = 0;
    prev_gnt    = '0;
    force_flag  = 1'b0;
    req         = '0;
    req_period  = '0;
    req_clk_src = '0;
    rst_n       = 1'b0;
    #1;
    checkOutput("reset_outputs", {gnt, done, busy, tmr_en, tmr_period, tmr_clk_src}, 64'd0);
    checkOutput("constants", {62'd0, tmr_up, tmr_one_shot}, 64'd1);
    doReset();

    // Single requester, period 5, clock source 8
    exp_gnt_q.push_back(4'b0001);
    exp_done_q.push_back(4'b0001);
    applyStimulus(0, 1'b1, 32'd5, 4'd8);
    tick();
    checkOutput("t1_gnt_c1", 64'(gnt), 64'b0001);
    checkOutput("t1_tmr_en_c1", 64'(tmr_en), 64'd0);
    checkOutput("t1_busy_c1", 64'(busy), 64'd1);
    checkOutput("t1_latch", {tmr_period, tmr_clk_src}, {32'd5, 4'd8});
    tick();
    checkOutput("t1_tmr_en_c2", 64'(tmr_en), 64'd1);
    waitDone(4'b0001, 20, cyc);
    checkOutput("t1_done_cycle", 64'(2 + cyc), 64'd8);
    checkOutput("t1_after_done", {gnt, tmr_en, busy}, 6'd0);
    tick();
    checkOutput("t1_masked", {gnt, done}, 8'd0);
    applyStimulus(0, 1'b0, 32'd5, 4'd8);
    tick();
    checkOutput("t1_idle", 64'(gnt), 64'd0);

    // All four requesting with period 3: grants 0,1,2,3 then 0
    doReset();
    order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int s = 0; s < 5; s++) begin
      exp_gnt_q.push_back(order[s]);
      exp_done_q.push_back(order[s]);
    end
    for (int k = 0; k < 4; k++) applyStimulus(k, 1'b1, 32'd3, 4'd1);
    for (int s = 0; s < 5; s++) waitDone(order[s], 20, cyc);
    req = '0;
    repeat (3) tick();

    // Zero-delay bypass on requester 2
    doReset();
    exp_done_q.push_back(4'b0100);
    applyStimulus(2, 1'b1, 32'd0, 4'd3);
    tick();
    checkOutput("t3_done", 64'(done), 64'b0100);
    checkOutput("t3_untouched", {gnt, tmr_en, busy}, 6'd0);
    applyStimulus(2, 1'b0, 32'd0, 4'd3);
    tick();
    checkOutput("t3_single_pulse", {done, gnt, tmr_en}, 9'd0);

    // Withdraw requester 1 while running
    doReset();
    exp_gnt_q.push_back(4'b0010);
    applyStimulus(1, 1'b1, 32'd100, 4'd2);
    repeat (20) tick();
    checkOutput("t4_running", {gnt, tmr_en}, {4'b0010, 1'b1});
    applyStimulus(1, 1'b0, 32'd100, 4'd2);
    tick();
    checkOutput("t4_withdrawn", {gnt, tmr_en, busy}, 6'd0);
    repeat (10) tick();

    // Asynchronous reset while running, then regrant from pointer 0
    doReset();
    exp_gnt_q.push_back(4'b0001);
    applyStimulus(0, 1'b1, 32'd50, 4'd4);
    applyStimulus(3, 1'b1, 32'd50, 4'd4);
    repeat (5) tick();
    checkOutput("t5_running", {gnt, tmr_en}, {4'b0001, 1'b1});
    rst_n = 1'b0;
    #1;
    checkOutput("t5_async_reset", {gnt, done, busy, tmr_en, tmr_period, tmr_clk_src}, 64'd0);
    exp_gnt_q.push_back(4'b0001);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    checkOutput("t5_regrant", 64'(gnt), 64'b0001);
    req = '0;
    repeat (3) tick();
    checkOutput("t5_released", {gnt, tmr_en}, 5'd0);

    // to_flag while IDLE is ignored; to_flag with simultaneous withdraw still completes
    doReset();
    force_flag = 1'b1;
    tick();
    force_flag = 1'b0;
    checkOutput("t6_idle_flag", {done, busy}, 5'd0);
    exp_gnt_q.push_back(4'b0100);
    exp_done_q.push_back(4'b0100);
    applyStimulus(2, 1'b1, 32'd1000, 4'd5);
    repeat (5) tick();
    force_flag = 1'b1;
    applyStimulus(2, 1'b0, 32'd1000, 4'd5);
    tick();
    force_flag = 1'b0;
    checkOutput("t6_flag_wins", {done, gnt, tmr_en}, {4'b0100, 4'b0000, 1'b0});
    tick();

    // Requester 3 keeps req high; pending requester 0 goes before it again
    doReset();
    exp_gnt_q.push_back(4'b1000);
    exp_done_q.push_back(4'b1000);
    exp_gnt_q.push_back(4'b0001);
    exp_done_q.push_back(4'b0001);
    exp_gnt_q.push_back(4'b1000);
    exp_done_q.push_back(4'b1000);
    applyStimulus(3, 1'b1, 32'd3, 4'd6);
    tick();
    applyStimulus(0, 1'b1, 32'd3, 4'd7);
    waitDone(4'b1000, 20, cyc);
    waitDone(4'b0001, 20, cyc);
    applyStimulus(0, 1'b0, 32'd3, 4'd7);
    waitDone(4'b1000, 20, cyc);
    applyStimulus(3, 1'b0, 32'd3, 4'd6);
    repeat (3) tick();

    checkOutput("grants_consumed", 64'(exp_gnt_q.size()), 64'd0);
    checkOutput("dones_consumed", 64'(exp_done_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
